// File: rtl/tx_interface_bb.sv
// Baseband TX output bridge: Wishbone-style slave in, FIFO, Wishbone-style
// master out, one output burst per input frame.
module tx_interface_bb #(
  parameter int ADDR_W = 4,
  parameter int DAT_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [DAT_W-1:0] DAT_I,
  input  logic             WE_I,
  input  logic             STB_I,
  input  logic             CYC_I,
  output logic             ACK_O,
  output logic [DAT_W-1:0] DAT_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I,
  output logic [CNT_W-1:0] FRM_CNT_O
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DAT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [CNT_W-1:0]  frm_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Reset gates the handshake so upstream never sees an ACK mid-reset.
  assign push = CYC_I & STB_I & WE_I & ~full
              & (state != DRAIN) & ~RST_I;
  assign pop  = STB_O & ACK_I;

  assign ACK_O     = push;
  assign DAT_O     = mem[rd_ptr];
  assign FRM_CNT_O = frm_cnt;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (push) state_nxt = STREAM;
      STREAM:  if (!CYC_I) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CYC_O = 1'b0;
    STB_O = 1'b0;
    WE_O  = 1'b0;
    if (state != IDLE) begin
      CYC_O = 1'b1;
      STB_O = ~empty;
      WE_O  = ~empty;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) begin
      mem[wr_ptr] <= DAT_I;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Cleared as a frame opens, then held after it closes for readback.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      frm_cnt <= '0;
    end else if (state == IDLE && push) begin
      frm_cnt <= '0;
    end else if (pop && frm_cnt != '1) begin
      frm_cnt <= frm_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_interface_bb.sv
// Scoreboard bench for tx_interface_bb: accepted samples queue up,
// a monitor checks order, framing and per-frame counts.
module tb_tx_interface_bb;

  logic        clk;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        WE_I;
  logic        STB_I;
  logic        CYC_I;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;
  logic [15:0] FRM_CNT_O;

  int checks;
  int failures;
  int ack_mode;
  int frame_push;

  logic [31:0] exp_q[$];
  int          frm_q[$];

  logic        prev_cyc;
  logic        prev_stall;
  logic [31:0] prev_dat;

  tx_interface_bb dut (
    .CLK_I(clk),
    .RST_I(RST_I),
    .DAT_I(DAT_I),
    .WE_I(WE_I),
    .STB_I(STB_I),
    .CYC_I(CYC_I),
    .ACK_O(ACK_O),
    .DAT_O(DAT_O),
    .CYC_O(CYC_O),
    .STB_O(STB_O),
    .WE_O(WE_O),
    .ACK_I(ACK_I),
    .FRM_CNT_O(FRM_CNT_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    failures++;
    $display("FAIL %s act=timeout exp=event", nm);
  endtask

  task automatic rec(input logic [31:0] d);
    exp_q.push_back(d);
    frame_push++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #2;
    case (ack_mode)
      0:       ACK_I = 1'b0;
      1:       ACK_I = 1'b1;
      default: ACK_I = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (RST_I) begin
      prev_cyc   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (CYC_O && !prev_cyc)
        chk("frm_start", 32'(FRM_CNT_O), 32'd0);
      if (!CYC_O && prev_cyc) begin
        if (frm_q.size() == 0) bad("frm_q_empty");
        else chk("frm_cnt", 32'(FRM_CNT_O), 32'(frm_q.pop_front()));
      end
      chk("we_o", 32'(WE_O), 32'(STB_O));
      if (STB_O && !CYC_O) bad("stb_no_cyc");
      if (prev_stall && STB_O) chk("dat_hold", DAT_O, prev_dat);
      if (STB_O && ACK_I) begin
        if (exp_q.size() == 0) bad("extra_pop");
        else chk("dat_o", DAT_O, exp_q.pop_front());
      end
      prev_cyc   = CYC_O;
      prev_stall = STB_O && !ACK_I;
      prev_dat   = DAT_O;
    end
  end

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = d;
    forever begin
      @(negedge clk);
      if (ACK_O) begin
        rec(d);
        step();
        STB_I = 1'b0;
        break;
      end
      step();
      n++;
      if (n > 500) begin
        bad("send_ack");
        break;
      end
    end
  endtask

  task automatic end_frame();
    int n;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    frm_q.push_back(frame_push);
    frame_push = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!CYC_O) break;
      n++;
      if (n > 500) begin
        bad("frame_drain");
        break;
      end
    end
    step();
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] s[20];
    int n;
    checks = 0;
    failures = 0;
    frame_push = 0;
    ack_mode = 0;
    ACK_I = 1'b0;
    RST_I = 1'b1;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = 32'h1234_5678;

    @(negedge clk);
    chk("rst_ack", 32'(ACK_O), 32'd0);
    step();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    step();
    RST_I = 1'b0;
    @(negedge clk);
    chk("rst_cyc", 32'(CYC_O), 32'd0);
    chk("rst_stb", 32'(STB_O), 32'd0);
    chk("rst_frm", 32'(FRM_CNT_O), 32'd0);
    step();

    // single sample
    ack_mode = 1;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = 32'h0800_F800;
    @(negedge clk);
    chk("single_ack", 32'(ACK_O), 32'd1);
    if (ACK_O) rec(DAT_I);
    step();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    frm_q.push_back(frame_push);
    frame_push = 0;
    @(negedge clk);
    chk("single_cyc1", 32'(CYC_O), 32'd1);
    chk("single_stb1", 32'(STB_O), 32'd1);
    chk("single_we1", 32'(WE_O), 32'd1);
    chk("single_dat1", DAT_O, 32'h0800_F800);
    step();
    @(negedge clk);
    chk("single_stb2", 32'(STB_O), 32'd0);
    chk("single_cyc2", 32'(CYC_O), 32'd1);
    step();
    @(negedge clk);
    chk("single_cyc3", 32'(CYC_O), 32'd0);
    chk("single_frm3", 32'(FRM_CNT_O), 32'd1);
    step();

    // backpressure, full, and full with simultaneous pop
    ack_mode = 0;
    for (int i = 0; i < 20; i++) s[i] = $urandom;
    for (int i = 0; i < 16; i++) send(s[i]);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = s[16];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_ack", 32'(ACK_O), 32'd0);
      chk("full_head", DAT_O, s[0]);
      step();
    end
    ack_mode = 1;
    @(negedge clk);
    chk("full_pop_ack", 32'(ACK_O), 32'd0);
    chk("full_pop_stb", 32'(STB_O), 32'd1);
    step();
    @(negedge clk);
    chk("after_pop_ack", 32'(ACK_O), 32'd1);
    if (ACK_O) rec(s[16]);
    step();
    for (int i = 17; i < 20; i++) send(s[i]);
    end_frame();

    // pointer wrap with random downstream stalls and upstream gaps
    ack_mode = 2;
    base = $urandom;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        CYC_I = 1'b1;
        STB_I = 1'($urandom_range(0, 1));
        WE_I  = ~STB_I;
        DAT_I = ~base;
        @(negedge clk);
        chk("gap_ack", 32'(ACK_O), 32'd0);
        step();
      end
      send(base + 32'(i));
    end
    end_frame();

    // frame hold-off while draining
    ack_mode = 0;
    for (int i = 0; i < 5; i++) send($urandom);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    frm_q.push_back(frame_push);
    frame_push = 0;
    step();
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("holdoff_ack", 32'(ACK_O), 32'd0);
      step();
    end
    ack_mode = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ACK_O) begin
        chk("holdoff_gap", 32'(CYC_O), 32'd0);
        chk("holdoff_drained", 32'(exp_q.size()), 32'd0);
        rec(DAT_I);
        step();
        break;
      end
      step();
      n++;
      if (n > 100) begin
        bad("holdoff_resume");
        break;
      end
    end
    send($urandom);
    send($urandom);
    end_frame();

    // async reset mid-frame
    ack_mode = 0;
    for (int i = 0; i < 8; i++) send($urandom);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = $urandom;
    #2;
    RST_I = 1'b1;
    #1;
    chk("arst_cyc", 32'(CYC_O), 32'd0);
    chk("arst_stb", 32'(STB_O), 32'd0);
    chk("arst_ack", 32'(ACK_O), 32'd0);
    exp_q.delete();
    frm_q.delete();
    frame_push = 0;
    step();
    step();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    #3;
    RST_I = 1'b0;
    step();
    ack_mode = 1;
    for (int i = 0; i < 3; i++) send($urandom);
    end_frame();

    repeat (4) step();
    chk("all_drained", 32'(exp_q.size()), 32'd0);
    chk("frames_seen", 32'(frm_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
